// File: rtl/ddr_xfer_engine.sv
// ddr_xfer_engine: moves 240-bit words between the DDR/DMA stream and the polynomial memory's DDR port.
// Define DDR_XFER_SKID_EN for a 2-entry output buffer (1 word/cycle UNLOAD); default is 1 entry.
module ddr_xfer_engine (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic         cmd_write,
   input  logic [8:0]   cmd_base,
   input  logic [8:0]   cmd_count,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [239:0] s_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [239:0] m_data,
   output logic         done,
   output logic         ddr_interrupt,
   output logic [8:0]   ddr_address,
   output logic         ddr_we,
   output logic [239:0] ddr_din,
   input  logic [239:0] ddr_dout
);
`ifdef DDR_XFER_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif
   localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, UNLOAD = 2'd2, DRAIN = 2'd3;
   logic [1:0]   state_q, state_d, occ_q, occ_d;
   logic [8:0]   addr_q, rem_q;
   logic         inflight_q, intr_q, done_q;
   logic [239:0] buf0_q, buf0_d;
   logic         accept, load_hs, issue, pop, last;
   assign cmd_ready     = state_q == IDLE;
   assign accept        = cmd_valid && cmd_ready;
   assign s_ready       = state_q == LOAD;
   assign load_hs       = s_ready && s_valid;
   assign m_valid       = occ_q != 2'd0;
   assign m_data        = buf0_q;
   assign pop           = m_valid && m_ready;
   assign last          = rem_q == 9'd0;
   // a read may only issue if its data is guaranteed a buffer slot on arrival
   assign issue         = state_q == UNLOAD &&
                          ({1'b0, occ_q} + {2'b0, inflight_q} < 3'(DEPTH) + {2'b0, pop});
   assign ddr_we        = load_hs;
   assign ddr_din       = s_ready ? s_data : '0;
   assign ddr_address   = addr_q;
   assign ddr_interrupt = intr_q;
   assign done          = done_q;
   assign occ_d         = occ_q + {1'b0, inflight_q} - {1'b0, pop};
   always_comb begin
      state_d = state_q;
      if (accept) state_d = cmd_write ? LOAD : UNLOAD;
      if (load_hs && last) state_d = IDLE;
      if (issue && last) state_d = DRAIN;
      // stay in DRAIN until the final read is captured and popped, so ddr_dout is never gated early
      if (state_q == DRAIN && !inflight_q && occ_q == {1'b0, pop}) state_d = IDLE;
   end
`ifdef DDR_XFER_SKID_EN
   logic [239:0] buf1_q, buf1_d;
   always_comb begin
      buf0_d = pop ? buf1_q : buf0_q;
      buf1_d = buf1_q;
      if (inflight_q && occ_q == {1'b0, pop}) buf0_d = ddr_dout;
      else if (inflight_q) buf1_d = ddr_dout;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) buf1_q <= '0;
      else buf1_q <= buf1_d;
`else
   assign buf0_d = inflight_q ? ddr_dout : buf0_q;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q    <= IDLE;
         intr_q     <= 1'b0;
         done_q     <= 1'b0;
         inflight_q <= 1'b0;
         occ_q      <= 2'd0;
         buf0_q     <= '0;
         addr_q     <= 9'd0;
         rem_q      <= 9'd0;
      end else begin
         state_q    <= state_d;
         intr_q     <= state_d != IDLE;
         done_q     <= state_q != IDLE && state_d == IDLE;
         inflight_q <= issue;
         occ_q      <= occ_d;
         buf0_q     <= buf0_d;
         if (accept) begin
            addr_q <= cmd_base;
            rem_q  <= cmd_count;
         end else if (load_hs || issue) begin
            addr_q <= addr_q + 9'd1;
            rem_q  <= rem_q - 9'd1;
         end
      end
endmodule
